// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg : stage state encoding and ID/EX field layout for pipe stages   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_st_t;

  localparam int IDEX_CTRL_W = 7;
  localparam int IDEX_DATA_W = 143;

  // Control field bit positions
  localparam int CTRL_REGDST_BIT   = 0;
  localparam int CTRL_ALUSRC_BIT   = 1;
  localparam int CTRL_ALUCTR_LSB   = 2;
  localparam int CTRL_MEMWRITE_BIT = 4;
  localparam int CTRL_MEMTOREG_BIT = 5;
  localparam int CTRL_REGWRITE_BIT = 6;

  // Payload field LSB positions (rs at the bottom, busa at the top)
  localparam int DATA_RS_LSB      = 0;
  localparam int DATA_PCPLUS4_LSB = 5;
  localparam int DATA_SIGN_LSB    = 37;
  localparam int DATA_RT_LSB      = 69;
  localparam int DATA_RD_LSB      = 74;
  localparam int DATA_BUSB_LSB    = 79;
  localparam int DATA_BUSA_LSB    = 111;

  function automatic logic [IDEX_CTRL_W-1:0] idex_ctrl_pack(
    input logic       reg_write,
    input logic       mem_to_reg,
    input logic       mem_write,
    input logic [1:0] alu_ctr,
    input logic       alu_src,
    input logic       reg_dst
  );
    return {reg_write, mem_to_reg, mem_write, alu_ctr, alu_src, reg_dst};
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_slot.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | skid_slot : one ctrl+data holding register with load and ctrl-clear      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module skid_slot #(
  parameter int CTRL_W     = 7,
  parameter int DATA_W     = 143,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Clear always empties ctrl; payload is only wiped when CLEAR_DATA asks for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= '0;
      if (CLEAR_DATA) r_data <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid : valid/ready pipeline register, 2-entry skid, flush     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = IDEX_CTRL_W,
  parameter int DATA_W     = IDEX_DATA_W,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  stage_st_t r_state, w_state_nxt;

  logic              w_in_fire, w_out_fire;
  logic              w_main_load, w_main_clear, w_main_from_skid;
  logic              w_skid_load, w_skid_clear;
  logic [CTRL_W-1:0] w_main_ctrl_in, w_skid_ctrl;
  logic [DATA_W-1:0] w_main_data_in, w_skid_data;

  assign in_ready   = (r_state != FULL) & ~flush & ~rst;
  assign out_valid  = (r_state != EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign occ        = (r_state == FULL) ? 2'd2 : (r_state == ONE) ? 2'd1 : 2'd0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_clear     = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_nxt  = EMPTY;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ONE;
            w_main_load = 1'b1;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = FULL;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            // Drain to a bubble: ctrl must read 0 while out_valid is low.
            w_state_nxt  = EMPTY;
            w_main_clear = 1'b1;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            w_state_nxt      = ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : in_ctrl;
  assign w_main_data_in = w_main_from_skid ? w_skid_data : in_data;

  skid_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_ctrl_in),
    .i_data  (w_main_data_in),
    .o_ctrl  (out_ctrl),
    .o_data  (out_data)
  );

  skid_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_ctrl  (in_ctrl),
    .i_data  (in_data),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_stage_skid : scoreboard bench, CLEAR_DATA=0 and =1 side by side  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int CW = 7;
  localparam int DW = 143;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready_c, out_valid_c;
  logic [CW-1:0] out_ctrl, out_ctrl_c;
  logic [DW-1:0] out_data, out_data_c;
  logic [1:0]    occ, occ_c;

  beat_t         q[$];
  logic [DW-1:0] last_pop;
  int            n_total = 0;
  int            n_bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_ctrl(out_ctrl_c), .out_data(out_data_c),
    .occ(occ_c)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[DW-1:0];
  endfunction

  // One cycle: drive at negedge, check against the model, then update the model.
  task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      input logic ordy, input logic fl, input logic rs);
    logic  exp_ir;
    beat_t b;
    @(negedge clk);
    in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl; rst = rs;
    #1;
    exp_ir = (q.size() < 2) && !fl && !rs;
    chk("occ", occ, q.size());
    chk("occ_c", occ_c, q.size());
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_valid_c", out_valid_c, q.size() != 0);
    chk("in_ready", in_ready, exp_ir);
    chk("in_ready_c", in_ready_c, exp_ir);
    if (q.size() != 0) begin
      chk("out_ctrl", out_ctrl, q[0].c);
      chk("out_data", out_data, q[0].d);
      chk("out_ctrl_c", out_ctrl_c, q[0].c);
      chk("out_data_c", out_data_c, q[0].d);
    end else begin
      chk("bubble_ctrl", out_ctrl, 0);
      chk("bubble_ctrl_c", out_ctrl_c, 0);
      chk("bubble_data_c", out_data_c, 0);
    end
    if (q.size() != 0 && ordy) begin
      b = q.pop_front();
      last_pop = b.d;
    end
    if (fl || rs) q.delete();
    else if (v && exp_ir) q.push_back('{c: c, d: d});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_ctrl = 7'h7f; in_data = rnd_data(); last_pop = '0;

    // Reset held two cycles with upstream valid asserted
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_occ", occ, 0);
    chk("rst_out_data", out_data, 0);

    // Full-rate stream, alternating control patterns
    for (int i = 1; i <= 10; i++)
      step(1'b1, (i % 2) ? 7'h41 : 7'h22, DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);

    // Fill both entries under stall, hold, then drain in order
    step(1'b1, 7'h15, DW'(16'hAAAA), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h2a, DW'(16'hBBBB), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h33, DW'(16'hDEAD), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h33, DW'(16'hDEAD), 1'b0, 1'b0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    chk("hold_data", out_data, last_pop);

    // Flush while full with a new beat offered
    step(1'b1, 7'h11, DW'(16'h1111), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h12, DW'(16'h2222), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h7c, DW'(16'hCCCC), 1'b1, 1'b1, 1'b0);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    chk("flush_data_c", out_data_c, 0);

    // Reset in the middle of a transfer
    step(1'b1, 7'h05, DW'(16'h5555), 1'b0, 1'b0, 1'b0);
    step(1'b1, 7'h06, DW'(16'h6666), 1'b1, 1'b0, 1'b1);
    step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_data", out_data, 0);

    // Random traffic with occasional flush
    for (int i = 0; i < 10000; i++)
      step(($urandom % 4) != 0, CW'($urandom), rnd_data(), ($urandom % 3) != 0,
           ($urandom % 64) == 0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 7'h00, '0, 1'b1, 1'b0, 1'b0);
    chk("final_empty", occ, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
